// File: rtl/adc_scan_pkg.sv
// Shared types and scaling helpers for the multi-channel ADC scan path.
// The /255 reciprocal is applied as *257 >> 16 with rounding.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GAP     = 3'd1,
        ST_SELECT  = 3'd2,
        ST_REQ     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_ACCUM   = 3'd5,
        ST_CONVERT = 3'd6,
        ST_EMIT    = 3'd7
    } scan_state_e;

    localparam int unsigned RECIP_MUL         = 32'd257;
    localparam int unsigned RECIP_SHIFT       = 32'd16;
    localparam int unsigned RECIP_ROUND       = 32'd32768;
    localparam int unsigned VREF_X100_DEFAULT = 32'd330;

    function automatic logic [15:0] calc_voltage(input logic [7:0] code,
                                                 input int unsigned vref_x100 = VREF_X100_DEFAULT);
        logic [39:0] prod;
        prod = 40'(code) * 40'(vref_x100) * 40'(RECIP_MUL) + 40'(RECIP_ROUND);
        return 16'(prod >> RECIP_SHIFT);
    endfunction

endpackage

// File: rtl/adc_code_to_volt.sv
// Registered 8-bit ADC code to volts x100 converter, one cycle of latency.
// The result holds until the next load.
module adc_code_to_volt
    import adc_scan_pkg::*;
#(
    parameter int unsigned VREF_X100 = VREF_X100_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  code,
    output logic [15:0] voltage
);

    logic [15:0] voltage_r;

    // capture the scaled voltage whenever a new code is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voltage_r <= 16'd0;
        end else if (load) begin
            voltage_r <= calc_voltage(code, VREF_X100);
        end
    end

    assign voltage = voltage_r;

endmodule

// File: rtl/adc_scan_sampler.sv
// Round-robin ADC scanner: requests reads from a byte-level I2C engine,
// drops post-switch reads, averages samples and emits code plus voltage.
module adc_scan_sampler
    import adc_scan_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned DISCARD        = 1,
    parameter int unsigned VREF_X100      = 330,
    parameter int unsigned GAP_CYCLES     = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              conv_req,
    output logic [CH_W-1:0]   conv_ch,
    input  logic              conv_done,
    input  logic [7:0]        conv_data,
    input  logic              conv_err,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic [7:0]        smp_code,
    output logic [15:0]       smp_voltage,
    output logic              busy,
    output logic              err_flag,
    output logic [7:0]        err_count
);

    localparam int unsigned      ACC_W        = 8 + AVG_LOG2;
    localparam int unsigned      CNT_W        = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] AVG_N        = CNT_W'(32'd1 << AVG_LOG2);
    localparam logic [1:0]       DISCARD_N    = 2'(DISCARD);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [31:0]      GAP_LAST     = 32'(GAP_CYCLES - 32'd1);

    scan_state_e      state_r, state_next_s;
    logic [CH_W-1:0]  ptr_r, sel_idx_s;
    logic [NUM_CH-1:0] mask_r, mask_rot_s;
    logic             sel_found_s, more_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] smp_cnt_r, smp_cnt_inc_s;
    logic [1:0]       disc_cnt_r;
    logic [7:0]       data_r, code_s;
    logic [31:0]      gap_cnt_r, to_cnt_r;
    logic             stop_r, stop_s;
    logic             ok_s, fail_s, timeout_s;
    logic             conv_req_s, busy_s, smp_valid_s;
    logic             conv_req_r, smp_valid_r, busy_r, err_flag_r;
    logic [CH_W-1:0]  conv_ch_r, smp_ch_r;
    logic [7:0]       smp_code_r, err_count_r;

    assign timeout_s     = (state_r == ST_WAIT) && !conv_done && (to_cnt_r == TIMEOUT_LAST);
    assign ok_s          = (state_r == ST_WAIT) && conv_done && !conv_err;
    assign fail_s        = ((state_r == ST_WAIT) && conv_done && conv_err) || timeout_s;
    assign stop_s        = stop_r || !enable;
    assign smp_cnt_inc_s = smp_cnt_r + CNT_W'(1'b1);
    assign code_s        = 8'(acc_r >> AVG_LOG2);

    // channel search: first set live-mask bit at or after the pointer, and whether any
    // latched-mask bit lies above the pointer (otherwise the scan wraps)
    always_comb begin
        mask_rot_s  = NUM_CH'({ch_mask, ch_mask} >> ptr_r);
        sel_found_s = 1'b0;
        sel_idx_s   = ptr_r;
        more_s      = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!sel_found_s && mask_rot_s[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = CH_W'((32'(ptr_r) + 32'(i)) % NUM_CH);
            end else begin
                sel_found_s = sel_found_s;
            end
            if (mask_r[i] && (i > int'(ptr_r))) begin
                more_s = 1'b1;
            end else begin
                more_s = more_s;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    state_next_s = (enable && (|ch_mask)) ? ST_SELECT : ST_IDLE;
            ST_GAP: begin
                if (!enable)                    state_next_s = ST_IDLE;
                else if (gap_cnt_r == GAP_LAST) state_next_s = ST_SELECT;
                else                            state_next_s = ST_GAP;
            end
            ST_SELECT:  state_next_s = (enable && sel_found_s) ? ST_REQ : ST_IDLE;
            ST_REQ:     state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (!(ok_s || fail_s))          state_next_s = ST_WAIT;
                else if (stop_s)                state_next_s = ST_IDLE;
                else if (fail_s)                state_next_s = ST_SELECT;
                else if (disc_cnt_r < DISCARD_N) state_next_s = ST_REQ;
                else                            state_next_s = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (!enable)                    state_next_s = ST_IDLE;
                else if (smp_cnt_inc_s == AVG_N) state_next_s = ST_CONVERT;
                else                            state_next_s = ST_REQ;
            end
            ST_CONVERT: state_next_s = enable ? ST_EMIT : ST_IDLE;
            ST_EMIT: begin
                if (!enable)                    state_next_s = ST_IDLE;
                else if (more_s)                state_next_s = ST_SELECT;
                else                            state_next_s = ST_GAP;
            end
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        conv_req_s  = (state_next_s == ST_WAIT);
        busy_s      = (state_next_s != ST_IDLE);
        smp_valid_s = (state_next_s == ST_EMIT);
    end

    // scan datapath: pointer, accumulator, counters, error bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= {CH_W{1'b0}};
            mask_r      <= {NUM_CH{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            smp_cnt_r   <= {CNT_W{1'b0}};
            disc_cnt_r  <= 2'd0;
            data_r      <= 8'd0;
            gap_cnt_r   <= 32'd0;
            to_cnt_r    <= 32'd0;
            stop_r      <= 1'b0;
            err_flag_r  <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ptr_r  <= {CH_W{1'b0}};
                    stop_r <= 1'b0;
                end
                ST_GAP:  gap_cnt_r <= gap_cnt_r + 32'd1;
                ST_SELECT: begin
                    ptr_r      <= sel_idx_s;
                    mask_r     <= ch_mask;
                    acc_r      <= {ACC_W{1'b0}};
                    smp_cnt_r  <= {CNT_W{1'b0}};
                    disc_cnt_r <= 2'd0;
                end
                ST_REQ: begin
                    to_cnt_r <= 32'd0;
                    if (!enable) stop_r <= 1'b1;
                end
                ST_WAIT: begin
                    to_cnt_r <= to_cnt_r + 32'd1;
                    if (!enable) stop_r <= 1'b1;
                    if (ok_s) begin
                        data_r <= conv_data;
                        if (disc_cnt_r < DISCARD_N) disc_cnt_r <= disc_cnt_r + 2'd1;
                    end
                    if (fail_s) begin
                        err_flag_r <= 1'b1;
                        if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
                    end
                end
                ST_ACCUM: begin
                    acc_r     <= acc_r + ACC_W'(data_r);
                    smp_cnt_r <= smp_cnt_inc_s;
                end
                ST_EMIT: begin
                    ptr_r     <= more_s ? (ptr_r + CH_W'(1'b1)) : {CH_W{1'b0}};
                    gap_cnt_r <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    // registered interface outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_req_r  <= 1'b0;
            conv_ch_r   <= {CH_W{1'b0}};
            smp_valid_r <= 1'b0;
            smp_ch_r    <= {CH_W{1'b0}};
            smp_code_r  <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            conv_req_r  <= conv_req_s;
            busy_r      <= busy_s;
            smp_valid_r <= smp_valid_s;
            if (state_r == ST_REQ) conv_ch_r <= ptr_r;
            if (smp_valid_s) begin
                smp_ch_r   <= ptr_r;
                smp_code_r <= code_s;
            end
        end
    end

    adc_code_to_volt #(
        .VREF_X100 (VREF_X100)
    ) u_code_to_volt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (smp_valid_s),
        .code    (code_s),
        .voltage (smp_voltage)
    );

    assign conv_req  = conv_req_r;
    assign conv_ch   = conv_ch_r;
    assign smp_valid = smp_valid_r;
    assign smp_ch    = smp_ch_r;
    assign smp_code  = smp_code_r;
    assign busy      = busy_r;
    assign err_flag  = err_flag_r;
    assign err_count = err_count_r;

endmodule

// File: doc/adc_scan_sampler.md
Name: adc_scan_sampler

Overview:
Parametrised successor to the single-channel ADC read path. It scans up to NUM_CH PCF8591-style inputs in round-robin order, drives a byte-level I2C conversion engine over a req/done handshake, and discards stale post-switch reads. It averages 2^AVG_LOG2 samples per channel and emits the averaged code plus a voltage scaled ×100, tagged with its channel, for the display path.

Parameters:
NUM_CH, 4, number of analog channels scanned (1..8)
CH_W, 2, channel index width, equal to max(1, clog2(NUM_CH))
AVG_LOG2, 2, log2 of samples averaged per result (0..4)
DISCARD, 1, reads dropped after each channel switch (0..3)
VREF_X100, 330, full-scale voltage ×100
GAP_CYCLES, 50000, idle clocks between complete scans
TIMEOUT_CYCLES, 200000, maximum wait for conv_done

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enabled
ch_mask  in  NUM_CH  channel enables; bit i=1 scans channel i
conv_req  out  1  request one conversion/read from the I2C engine
conv_ch  out  CH_W  channel for the request; stable while conv_req=1
conv_done  in  1  one-cycle pulse; the transaction has finished
conv_data  in  8  read byte; valid when conv_done=1
conv_err  in  1  NACK/bus error; qualified by conv_done
smp_valid  out  1  one-cycle result strobe
smp_ch  out  CH_W  channel of the result
smp_code  out  8  averaged ADC code
smp_voltage  out  16  code converted to volts ×100
busy  out  1  1 in any state other than IDLE
err_flag  out  1  sticky error; cleared only by reset
err_count  out  8  saturating count of errors and timeouts

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, channel pointer 0, accumulator and counters 0.
- States: IDLE, GAP, SELECT, REQ, WAIT, ACCUM, CONVERT, EMIT.
- IDLE: when enable=1 and ch_mask≠0, go to SELECT and start at the lowest set mask bit. ch_mask=0 holds IDLE.
- SELECT: choose the next set mask bit at or after the pointer, wrapping at NUM_CH-1. Clear the accumulator, the sample count and the discard count. Go to REQ.
- REQ: conv_req=1 and conv_ch=pointer. Go to WAIT the same cycle. conv_req stays high until conv_done.
- WAIT: conv_req=1.
  - conv_done with conv_err=0, while the discard count < DISCARD: increment the discard count, drop the byte, return to REQ. conv_req drops for exactly 1 cycle between requests.
  - conv_done with conv_err=0, after discards are complete: go to ACCUM.
  - conv_done with conv_err=1: set err_flag, increment err_count (saturates at 255), go to SELECT on the same channel, restarting its discards.
  - Timeout (TIMEOUT_CYCLES clocks in WAIT without conv_done): handled like conv_err=1.
- ACCUM: acc += conv_data. acc width is 8+AVG_LOG2. The sample count increments. If the count reaches 2^AVG_LOG2, go to CONVERT; otherwise go to REQ.
- CONVERT: code = acc >> AVG_LOG2 (truncating).
  - voltage = (code*VREF_X100*257 + 32768) >> 16, using an intermediate of at least 34 bits.
  - Reference values with VREF_X100=330: code 255→330, 128→166, 0→0.
- EMIT: smp_valid=1 for 1 cycle; smp_ch, smp_code and smp_voltage are updated the same cycle and hold until the next EMIT.
  - Latency: smp_valid rises exactly 3 clocks after the conv_done of the final sample.
  - Advance the pointer. Wrapping past the last set bit ends the scan and goes to GAP; otherwise go to SELECT.
- GAP: count GAP_CYCLES, then go to SELECT with a re-evaluated mask. ch_mask is sampled only in IDLE, SELECT and GAP end.
- enable deasserted:
  - In REQ or WAIT: the current transaction completes; conv_req is never dropped before conv_done. Then go to IDLE with no EMIT.
  - In GAP, SELECT, ACCUM or CONVERT: go to IDLE next cycle, with no EMIT.
  - In EMIT: the EMIT cycle completes (smp_valid=1), then go to IDLE.
- conv_done while not in WAIT is ignored.
- Reset mid-transaction drops conv_req immediately; the engine tolerates this.

Decomposition:
- Package adc_scan_pkg holds:
  - the state enum;
  - localparams for the /255 reciprocal (257, 16-bit shift, rounding 32768);
  - the default VREF_X100;
  - the function calc_voltage(code).
- One sub-module, adc_code_to_volt: registered code→voltage multiplier, 1-cycle latency, reused by the display path.

Test Plan:
- NUM_CH=4, mask=4'b1111, AVG_LOG2=2, DISCARD=1; engine returns 100,100,100,100,100 per channel → 4 EMITs in order ch0..3, each with code=100 and voltage=129. conv_done count before each EMIT = 5.
- mask=4'b1010; per-sample data 10,20,30,40 after the discard → EMITs only for ch1 and ch3, each with code=25 and voltage=32. Wrap returns to ch1 after GAP_CYCLES, measured from the last EMIT.
- conv_err=1 on the 3rd conv_done of ch2 → err_flag=1, err_count=1, ch2 restarts including its discard. Its result uses only post-error samples.
- Engine silent with TIMEOUT_CYCLES=100 → conv_req held for 100 cycles, then low for at least 1 cycle, err_count increments, and ch0 is retried.
- 256 forced errors → err_count saturates at 255 and smp_valid never fires.
- enable dropped mid-WAIT → conv_req held until conv_done, then busy=0 within 1 cycle and no smp_valid. rst_n asserted mid-WAIT → all outputs 0 asynchronously.
